// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: decodes each accepted instruction into
// {imm, fmt, tag} and queues it in a 2-entry elastic buffer toward execute.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [2:0] {
    FMT_R   = 3'b000,
    FMT_I   = 3'b001,
    FMT_S   = 3'b010,
    FMT_B   = 3'b011,
    FMT_U   = 3'b100,
    FMT_J   = 3'b101,
    FMT_ILL = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  // ---------------------------------------------------------------- decode
  fmt_e               fmt_dec;
  logic signed [31:0] imm32;
  entry_t             new_entry;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the case statements leaves it unassigned (no latch).
  always_comb begin
    fmt_dec = FMT_ILL;
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC:                    fmt_dec = FMT_U;
      OP_JAL:                              fmt_dec = FMT_J;
      OP_BRANCH:                           fmt_dec = FMT_B;
      OP_STORE:                            fmt_dec = FMT_S;
      OP_OP:                               fmt_dec = FMT_R;
      OP_JALR, OP_LOAD, OP_IMM,
      OP_MISC, OP_SYSTEM:                  fmt_dec = FMT_I;
      OP_IMM32: if (XLEN == 64)            fmt_dec = FMT_I;
      OP_OP32:  if (XLEN == 64)            fmt_dec = FMT_R;
      default:                             fmt_dec = FMT_ILL;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt_dec)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed cast sign-extends the 32-bit immediate to XLEN.
  assign new_entry.imm = XLEN'(imm32);
  assign new_entry.fmt = fmt_dec;
  assign new_entry.tag = in_tag;

  // ---------------------------------------------------------------- buffer
  entry_t           mem_q [2];
  logic [1:0]       count_q,  count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             ready_en_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // ready_en_q holds in_ready low during reset and for the edge it releases on.
  assign in_ready  = ready_en_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (push && fmt_dec == FMT_ILL && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ready_en_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_en_q <= 1'b1;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; the head is masked
  // below whenever the buffer is empty, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  // ---------------------------------------------------------------- outputs
  entry_t head;

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (!out_valid) begin
      head.imm = '0;
      head.fmt = FMT_ILL;
      head.tag = '0;
    end
  end

  assign out_imm       = head.imm;
  assign out_fmt       = head.fmt;
  assign out_illegal   = (head.fmt == FMT_ILL);
  assign out_tag       = head.tag;
  assign illegal_count = cnt_q;

endmodule
